// File: rtl/pipe_reg_tapped.sv
// pipe_reg_tapped: DEPTH-stage data/valid shift chain with runtime output tap and occupancy count
module pipe_reg_tapped #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int TW = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkE,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] out_mux_reg,
    output logic             out_valid,
    output logic [TW-1:0]    occ
);
    logic [WIDTH-1:0] d [1:DEPTH];
    logic [DEPTH:1]   v;
    logic [WIDTH-1:0] m_d [0:DEPTH];
    logic [DEPTH:0]   m_v;
    logic [TW-1:0]    tap;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) d[k] <= RST_VAL;
            v   <= '0;
            occ <= '0;
        end else if (flush) begin
            v   <= '0;
            occ <= '0;
        end else if (clkE) begin
            d[1] <= in;
            v[1] <= in_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                d[k] <= d[k-1];
                v[k] <= v[k-1];
            end
            occ <= occ + TW'(in_valid) - TW'(v[DEPTH]);
        end
    end
    always_comb begin
        m_d[0] = in;
        m_v[0] = in_valid;
        for (int k = 1; k <= DEPTH; k++) begin
            m_d[k] = d[k];
            m_v[k] = v[k];
        end
        tap         = (tap_sel > TW'(DEPTH)) ? TW'(DEPTH) : tap_sel;
        out_mux_reg = m_d[tap];
        out_valid   = m_v[tap];
    end
endmodule
